hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Watches the instruction being decoded, the instruction held in the ID/EX register, and the EX-stage redirect.
- Drives PC/IF stall, the ID_Stall/ID_Flush inputs of the decode stage, and the IF flush.
- Small FSM handles multi-cycle load-use bubbles, multi-cycle redirect flushes, and trap halt/resume.

Parameters:
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard; legal 1..4.
- FLUSH_CYCLES, 1, cycles IF/ID are flushed after a redirect; legal 1..4.
- CNT_WIDTH, 32, width of performance counters (optional feature only).

Ports:
- Clk  in  1  pipeline clock.
- Reset_n  in  1  reset, asynchronous, active-low.
- IF_valid  in  1  instruction at decode input is valid.
- Dec_Rs1_addr  in  5  rs1 of instruction being decoded.
- Dec_Rs2_addr  in  5  rs2 of instruction being decoded.
- Dec_Rs1_used  in  1  decoded instruction reads rs1.
- Dec_Rs2_used  in  1  decoded instruction reads rs2.
- Dec_trap  in  1  decoder flags illegal/ECALL/EBREAK.
- ID_Rd_addr  in  5  rd of instruction in ID/EX register.
- ID_Mem_rd_en  in  1  instruction in ID/EX is a load.
- EX_Redirect  in  1  taken branch or jump resolved in EX.
- Resume  in  1  single-cycle pulse; leave halt.
- PC_Stall  out  1  hold PC.
- IF_Stall  out  1  hold IF/ID register.
- IF_Flush  out  1  zero IF/ID register.
- ID_Stall  out  1  to decode stage; bubble ID/EX control.
- ID_Flush  out  1  to decode stage; clear ID/EX.
- Halted  out  1  core halted on trap.
- Stall_count  out  CNT_WIDTH  load-use bubble cycles (optional).
- Flush_count  out  CNT_WIDTH  redirect-flush cycles (optional).

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous, active-low. Reset forces state RUN, remaining-cycle counter to 0, and Halted to 0.
- Output timing: outputs are combinational from state and inputs (Mealy), so a hazard is acted on in the cycle it is detected.
- Reset values: while Reset_n is low, all stall/flush outputs are 0 and the optional counters are 0.
- Load-use hazard (LU): ID_Mem_rd_en=1, ID_Rd_addr!=0, IF_valid=1, and either (Dec_Rs1_used and Dec_Rs1_addr==ID_Rd_addr) or (Dec_Rs2_used and Dec_Rs2_addr==ID_Rd_addr).
- FSM states: RUN, LU_WAIT, FLUSH, HALT.
- RUN, priority EX_Redirect > Dec_trap > LU:
  - EX_Redirect: IF_Flush=1, ID_Flush=1. If FLUSH_CYCLES>1, go to FLUSH with remaining=FLUSH_CYCLES-1.
  - Dec_trap with IF_valid: ID_Flush=1, PC_Stall=1, IF_Stall=1; go to HALT next cycle. The trapping instruction never enters ID/EX.
  - LU: PC_Stall=1, IF_Stall=1, ID_Stall=1. If LOAD_USE_CYCLES>1, go to LU_WAIT with remaining=LOAD_USE_CYCLES-1.
  - Otherwise all outputs are 0.
- LU_WAIT: PC_Stall=1, IF_Stall=1, ID_Stall=1; remaining decrements each cycle; return to RUN after the cycle in which remaining==1.
  - EX_Redirect in LU_WAIT preempts it: behave as the RUN redirect case (flush, load FLUSH counter).
  - The LU condition is not re-evaluated during LU_WAIT.
- FLUSH: IF_Flush=1, ID_Flush=1; remaining decrements; return to RUN after remaining==1.
  - A new EX_Redirect reloads remaining to FLUSH_CYCLES-1; if FLUSH_CYCLES==1, return to RUN.
  - Dec_trap and LU are ignored (wrong-path instructions).
- HALT: PC_Stall=1, IF_Stall=1, ID_Flush=1, Halted=1 every cycle. Resume=1 gives RUN next cycle with Halted=0. EX_Redirect is ignored in HALT.
- Resume outside HALT has no effect.
- Asserting Reset_n low in any state returns to RUN immediately (asynchronously).
- ID_Stall and ID_Flush are never both 1. Flush dominates: when flushing, ID_Stall=0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Stall_count increments each cycle ID_Stall=1.
  - Flush_count increments each cycle IF_Flush=1.
  - Both saturate at all-ones, are cleared by reset, and are registered (update visible the cycle after the event).
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Load-use, defaults: ID_Mem_rd_en=1, ID_Rd_addr=5, Dec_Rs2_used=1, Dec_Rs2_addr=5 for one cycle -> PC_Stall/IF_Stall/ID_Stall=1 that cycle only. Repeat with ID_Rd_addr=0 -> no stall.
- LOAD_USE_CYCLES=3: same hazard pulsed one cycle -> stalls high exactly 3 cycles. Redirect in 2nd cycle -> IF_Flush/ID_Flush that cycle, ID_Stall=0.
- FLUSH_CYCLES=2: EX_Redirect pulse -> IF_Flush=ID_Flush=1 for 2 cycles. Second redirect in cycle 2 -> flush extends to 3 cycles total.
- Trap: Dec_trap=1, IF_valid=1 -> ID_Flush=1 that cycle, Halted=1 next cycle and held 10 cycles. Resume pulse -> Halted=0, all outputs 0 the next cycle.
- Simultaneous events: EX_Redirect=1 together with Dec_trap=1 and an LU hazard -> flush only, never HALT, ID_Stall=0.
- Reset mid-LU_WAIT (LOAD_USE_CYCLES=4), Reset_n low 1 cycle -> outputs 0 immediately. With HAZARD_PERF_CNT_EN, Stall_count reads 0, then 4 after one clean hazard.

Source files
------------

// File: rtl/hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller_if
// Description : Bundles the pipeline-observation inputs and stall/flush
//               control outputs of the hazard controller.
//               master : pipeline side (drives observations, receives controls)
//               slave  : hazard controller side
//               Signals:
//                 IF_valid, Dec_Rs1_addr, Dec_Rs2_addr, Dec_Rs1_used,
//                 Dec_Rs2_used, Dec_trap, ID_Rd_addr, ID_Mem_rd_en,
//                 EX_Redirect, Resume              (pipeline -> controller)
//                 PC_Stall, IF_Stall, IF_Flush, ID_Stall, ID_Flush, Halted,
//                 Stall_count, Flush_count         (controller -> pipeline)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 IF_valid;
  logic [4:0]           Dec_Rs1_addr;
  logic [4:0]           Dec_Rs2_addr;
  logic                 Dec_Rs1_used;
  logic                 Dec_Rs2_used;
  logic                 Dec_trap;
  logic [4:0]           ID_Rd_addr;
  logic                 ID_Mem_rd_en;
  logic                 EX_Redirect;
  logic                 Resume;
  logic                 PC_Stall;
  logic                 IF_Stall;
  logic                 IF_Flush;
  logic                 ID_Stall;
  logic                 ID_Flush;
  logic                 Halted;
  logic [CNT_WIDTH-1:0] Stall_count;
  logic [CNT_WIDTH-1:0] Flush_count;

  modport master (
    output IF_valid, Dec_Rs1_addr, Dec_Rs2_addr, Dec_Rs1_used, Dec_Rs2_used,
           Dec_trap, ID_Rd_addr, ID_Mem_rd_en, EX_Redirect, Resume,
    input  PC_Stall, IF_Stall, IF_Flush, ID_Stall, ID_Flush, Halted,
           Stall_count, Flush_count
  );

  modport slave (
    input  IF_valid, Dec_Rs1_addr, Dec_Rs2_addr, Dec_Rs1_used, Dec_Rs2_used,
           Dec_trap, ID_Rd_addr, ID_Mem_rd_en, EX_Redirect, Resume,
    output PC_Stall, IF_Stall, IF_Flush, ID_Stall, ID_Flush, Halted,
           Stall_count, Flush_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Stall/flush sequencer for a 5-stage RV32I pipeline. Detects
//               load-use hazards, applies EX-stage redirect flushes and halts
//               the core on a decode trap until Resume. Outputs are Mealy:
//               a hazard is acted on in the cycle it is detected.
//               Ports:
//                 Clk     - pipeline clock
//                 Reset_n - asynchronous active-low reset
//                 bus     - hazard_controller_if.slave (observations in,
//                           stall/flush/halt controls and counters out)
//               Optional feature macro: HAZARD_PERF_CNT_EN
//                 defined   - saturating Stall_count / Flush_count counters
//                 undefined - both counters tied to 0, no flops built
//               CNT_WIDTH must match the CNT_WIDTH of the connected interface.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
  parameter int LOAD_USE_CYCLES = 1,  // 1..4
  parameter int FLUSH_CYCLES    = 1,  // 1..4
  parameter int CNT_WIDTH       = 32
) (
  input  wire logic          Clk,
  input  wire logic          Reset_n,
  hazard_controller_if.slave bus
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LU_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

  // Remaining-cycle reload values: the detecting cycle is the first bubble /
  // flush cycle, so the wait states only cover the extra ones.
  localparam logic [1:0] c_LU_RELOAD = 2'(LOAD_USE_CYCLES - 1);
  localparam logic [1:0] c_FL_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam bit         c_LU_MULTI  = (LOAD_USE_CYCLES > 1);
  localparam bit         c_FL_MULTI  = (FLUSH_CYCLES > 1);

  logic [1:0] state_q, state_d;
  logic [1:0] remain_q, remain_d;

  logic w_rs1_hit, w_rs2_hit, w_load_use;
  logic w_pc_stall, w_if_stall, w_if_flush, w_id_stall, w_id_flush;

  always_comb begin
    w_rs1_hit  = bus.Dec_Rs1_used && (bus.Dec_Rs1_addr == bus.ID_Rd_addr);
    w_rs2_hit  = bus.Dec_Rs2_used && (bus.Dec_Rs2_addr == bus.ID_Rd_addr);
    w_load_use = bus.ID_Mem_rd_en && (bus.ID_Rd_addr != 5'd0) && bus.IF_valid
                 && (w_rs1_hit || w_rs2_hit);
  end

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    w_pc_stall = 1'b0;
    w_if_stall = 1'b0;
    w_if_flush = 1'b0;
    w_id_stall = 1'b0;
    w_id_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.EX_Redirect) begin
          w_if_flush = 1'b1;
          w_id_flush = 1'b1;
          if (c_FL_MULTI) begin
            state_d  = ST_FLUSH;
            remain_d = c_FL_RELOAD;
          end
        end else if (bus.Dec_trap && bus.IF_valid) begin
          // Trapping instruction is squashed before it reaches ID/EX.
          w_id_flush = 1'b1;
          w_pc_stall = 1'b1;
          w_if_stall = 1'b1;
          state_d    = ST_HALT;
        end else if (w_load_use) begin
          w_pc_stall = 1'b1;
          w_if_stall = 1'b1;
          w_id_stall = 1'b1;
          if (c_LU_MULTI) begin
            state_d  = ST_LU_WAIT;
            remain_d = c_LU_RELOAD;
          end
        end
      end
      ST_LU_WAIT: begin
        if (bus.EX_Redirect) begin
          // Redirect pre-empts the remaining bubbles; flush dominates stall.
          w_if_flush = 1'b1;
          w_id_flush = 1'b1;
          if (c_FL_MULTI) begin
            state_d  = ST_FLUSH;
            remain_d = c_FL_RELOAD;
          end else begin
            state_d  = ST_RUN;
            remain_d = 2'd0;
          end
        end else begin
          w_pc_stall = 1'b1;
          w_if_stall = 1'b1;
          w_id_stall = 1'b1;
          if (remain_q == 2'd1) begin
            state_d  = ST_RUN;
            remain_d = 2'd0;
          end else begin
            remain_d = remain_q - 2'd1;
          end
        end
      end
      ST_FLUSH: begin
        // Decode contents are wrong-path: traps and load-use are ignored.
        w_if_flush = 1'b1;
        w_id_flush = 1'b1;
        if (bus.EX_Redirect && c_FL_MULTI) begin
          remain_d = c_FL_RELOAD;
        end else if (bus.EX_Redirect || (remain_q == 2'd1)) begin
          state_d  = ST_RUN;
          remain_d = 2'd0;
        end else begin
          remain_d = remain_q - 2'd1;
        end
      end
      ST_HALT: begin
        w_pc_stall = 1'b1;
        w_if_stall = 1'b1;
        w_id_flush = 1'b1;
        if (bus.Resume) begin
          state_d  = ST_RUN;
          remain_d = 2'd0;
        end
      end
      default: begin
        state_d  = ST_RUN;
        remain_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_RUN;
      remain_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  // Gated with Reset_n so the Mealy outputs are quiet for the whole reset.
  assign bus.PC_Stall = Reset_n & w_pc_stall;
  assign bus.IF_Stall = Reset_n & w_if_stall;
  assign bus.IF_Flush = Reset_n & w_if_flush;
  assign bus.ID_Stall = Reset_n & w_id_stall;
  assign bus.ID_Flush = Reset_n & w_id_flush;
  assign bus.Halted   = Reset_n & (state_q == ST_HALT);

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = 1;

  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_id_stall && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + c_CNT_ONE;
      end
      if (w_if_flush && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + c_CNT_ONE;
      end
    end
  end

  assign bus.Stall_count = stall_cnt_q;
  assign bus.Flush_count = flush_cnt_q;
`else
  assign bus.Stall_count = '0;
  assign bus.Flush_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller
// Description : Self-checking bench. Three controllers with different
//               LOAD_USE_CYCLES / FLUSH_CYCLES / CNT_WIDTH share one stimulus
//               stream; each is compared every cycle against a countdown
//               reference model. Honours HAZARD_PERF_CNT_EN for the counters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_controller;
  localparam int N = 3;
  localparam int P_LUC [N] = '{1, 3, 4};
  localparam int P_FC  [N] = '{1, 2, 1};
  localparam int P_CW  [N] = '{32, 32, 3};
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // Stimulus codes: {lu, lu_with_rd0, trap, redirect, resume}
  localparam logic [4:0] IDL = 5'b00000;
  localparam logic [4:0] LU  = 5'b10000;
  localparam logic [4:0] LU0 = 5'b11000;
  localparam logic [4:0] TRP = 5'b00100;
  localparam logic [4:0] RDR = 5'b00010;
  localparam logic [4:0] RSM = 5'b00001;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, in_rs1u, in_rs2u, in_trap, in_memrd, in_redir, in_resume;
  logic [4:0] in_rs1, in_rs2, in_rd;

  logic [5:0]  obs    [N];  // {Halted, PC_Stall, IF_Stall, IF_Flush, ID_Stall, ID_Flush}
  logic [31:0] obs_sc [N];
  logic [31:0] obs_fc [N];

  int     tests_run    = 0;
  int     tests_failed = 0;
  int     m_halt       [N];
  int     m_stall_left [N];
  int     m_flush_left [N];
  longint m_scnt       [N];
  longint m_fcnt       [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    hazard_controller_if #(.CNT_WIDTH(P_CW[g])) bus ();
    assign bus.IF_valid     = in_valid;
    assign bus.Dec_Rs1_addr = in_rs1;
    assign bus.Dec_Rs2_addr = in_rs2;
    assign bus.Dec_Rs1_used = in_rs1u;
    assign bus.Dec_Rs2_used = in_rs2u;
    assign bus.Dec_trap     = in_trap;
    assign bus.ID_Rd_addr   = in_rd;
    assign bus.ID_Mem_rd_en = in_memrd;
    assign bus.EX_Redirect  = in_redir;
    assign bus.Resume       = in_resume;

    hazard_controller #(
      .LOAD_USE_CYCLES(P_LUC[g]),
      .FLUSH_CYCLES   (P_FC[g]),
      .CNT_WIDTH      (P_CW[g])
    ) u_dut (
      .Clk    (clk),
      .Reset_n(rst_n),
      .bus    (bus.slave)
    );

    assign obs[g]    = {bus.Halted, bus.PC_Stall, bus.IF_Stall,
                        bus.IF_Flush, bus.ID_Stall, bus.ID_Flush};
    assign obs_sc[g] = 32'(bus.Stall_count);
    assign obs_fc[g] = 32'(bus.Flush_count);
  end

  // ---------------- reference model ----------------
  function automatic bit lu_hit();
    return in_memrd && (in_rd != 5'd0) && in_valid &&
           ((in_rs1u && in_rs1 == in_rd) || (in_rs2u && in_rs2 == in_rd));
  endfunction

  function automatic logic [5:0] model_out(int k);
    if (m_halt[k] != 0)                        return 6'b111001;
    if (in_redir || m_flush_left[k] > 0)       return 6'b000101;
    if (m_stall_left[k] > 0)                   return 6'b011010;
    if (in_trap && in_valid)                   return 6'b011001;
    if (lu_hit())                              return 6'b011010;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] exp_cnt(longint v);
    return PERF_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_halt[k] = 0; m_stall_left[k] = 0; m_flush_left[k] = 0;
      m_scnt[k] = 0; m_fcnt[k] = 0;
    end
  endtask

  task automatic model_advance();
    for (int k = 0; k < N; k++) begin
      logic [5:0] o;
      longint     cmax;
      o    = model_out(k);
      cmax = (64'd1 << P_CW[k]) - 1;
      if (o[1] && m_scnt[k] < cmax) m_scnt[k]++;
      if (o[2] && m_fcnt[k] < cmax) m_fcnt[k]++;
      if (m_halt[k] != 0) begin
        if (in_resume) m_halt[k] = 0;
      end else if (in_redir) begin
        m_flush_left[k] = P_FC[k] - 1;
        m_stall_left[k] = 0;
      end else if (m_flush_left[k] > 0) begin
        m_flush_left[k]--;
      end else if (m_stall_left[k] > 0) begin
        m_stall_left[k]--;
      end else if (in_trap && in_valid) begin
        m_halt[k] = 1;
      end else if (lu_hit()) begin
        m_stall_left[k] = P_LUC[k] - 1;
      end
    end
  endtask

  task automatic drive(input logic [4:0] c);
    in_valid  = 1'b1;
    in_rs1u   = 1'b0;
    in_rs1    = 5'd0;
    in_rs2u   = 1'b1;
    in_memrd  = c[4];
    in_rd     = c[4] ? (c[3] ? 5'd0 : 5'd5) : 5'd7;
    in_rs2    = c[4] ? in_rd : 5'd3;
    in_trap   = c[2];
    in_redir  = c[1];
    in_resume = c[0];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(LU | RDR);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      tests_run += 3;
      if (obs[k] !== 6'b0) begin
        tests_failed++;
        $display("FAIL reset_out dut%0d: got %b want %b", k, obs[k], 6'b0);
      end
      if (obs_sc[k] !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_scnt dut%0d: got %0d want 0", k, obs_sc[k]);
      end
      if (obs_fc[k] !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_fcnt dut%0d: got %0d want 0", k, obs_fc[k]);
      end
    end
    drive(IDL);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    logic [4:0] seq [8] = '{LU, IDL, IDL, IDL, LU0, IDL, LU, IDL};
    for (int i = 0; i < 8; i++) begin
      drive(seq[i]);
      #3;
      for (int k = 0; k < N; k++) begin
        tests_run++;
        if (obs[k] !== model_out(k)) begin
          tests_failed++;
          $display("FAIL load_use dut%0d step%0d: got %b want %b", k, i, obs[k], model_out(k));
        end
      end
      model_advance();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lu_redirect();
    logic [4:0] seq [6] = '{LU, RDR, IDL, IDL, IDL, IDL};
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      #3;
      for (int k = 0; k < N; k++) begin
        tests_run++;
        if (obs[k] !== model_out(k)) begin
          tests_failed++;
          $display("FAIL lu_redirect dut%0d step%0d: got %b want %b", k, i, obs[k], model_out(k));
        end
      end
      model_advance();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    logic [4:0] seq [9] = '{RDR, IDL, IDL, RDR, RDR, IDL, IDL, RDR | TRP, IDL};
    for (int i = 0; i < 9; i++) begin
      drive(seq[i]);
      #3;
      for (int k = 0; k < N; k++) begin
        tests_run++;
        if (obs[k] !== model_out(k)) begin
          tests_failed++;
          $display("FAIL flush dut%0d step%0d: got %b want %b", k, i, obs[k], model_out(k));
        end
      end
      model_advance();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    logic [4:0] seq [17] = '{TRP, IDL, IDL, RDR, IDL, LU, IDL, IDL, IDL, IDL,
                             IDL, RSM, IDL, RSM, IDL, RDR, IDL};
    for (int i = 0; i < 17; i++) begin
      drive(seq[i]);
      #3;
      for (int k = 0; k < N; k++) begin
        tests_run++;
        if (obs[k] !== model_out(k)) begin
          tests_failed++;
          $display("FAIL trap dut%0d step%0d: got %b want %b", k, i, obs[k], model_out(k));
        end
      end
      model_advance();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] seq [5] = '{LU | TRP | RDR, IDL, IDL, LU | TRP, IDL};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      #3;
      for (int k = 0; k < N; k++) begin
        tests_run++;
        if (obs[k] !== model_out(k)) begin
          tests_failed++;
          $display("FAIL simultaneous dut%0d step%0d: got %b want %b", k, i, obs[k], model_out(k));
        end
      end
      model_advance();
      @(posedge clk); #1;
    end
    drive(RSM);  // leave the halt entered by the trap above
    model_advance();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    drive(LU);  model_advance(); @(posedge clk); #1;
    drive(IDL); model_advance(); @(posedge clk); #1;
    // dut2 (LOAD_USE_CYCLES=4) is now mid-LU_WAIT and stalling
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      tests_run += 3;
      if (obs[k] !== 6'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_out dut%0d: got %b want %b", k, obs[k], 6'b0);
      end
      if (obs_sc[k] !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_mid_scnt dut%0d: got %0d want 0", k, obs_sc[k]);
      end
      if (obs_fc[k] !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_mid_fcnt dut%0d: got %0d want 0", k, obs_fc[k]);
      end
    end
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      drive(i == 0 ? LU : IDL);
      #3;
      for (int k = 0; k < N; k++) begin
        tests_run += 2;
        if (obs[k] !== model_out(k)) begin
          tests_failed++;
          $display("FAIL reset_mid_lu dut%0d step%0d: got %b want %b", k, i, obs[k], model_out(k));
        end
        if (obs_sc[k] !== exp_cnt(m_scnt[k])) begin
          tests_failed++;
          $display("FAIL reset_mid_scnt dut%0d step%0d: got %0d want %0d", k, i, obs_sc[k], exp_cnt(m_scnt[k]));
        end
      end
      model_advance();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) != 0);
      in_rs1    = 5'($urandom_range(0, 3));
      in_rs2    = 5'($urandom_range(0, 3));
      in_rd     = 5'($urandom_range(0, 3));
      in_rs1u   = 1'($urandom_range(0, 1));
      in_rs2u   = 1'($urandom_range(0, 1));
      in_memrd  = ($urandom_range(0, 9) < 5);
      in_trap   = ($urandom_range(0, 19) == 0);
      in_redir  = ($urandom_range(0, 9) == 0);
      in_resume = ($urandom_range(0, 3) == 0);
      #3;
      for (int k = 0; k < N; k++) begin
        tests_run += 3;
        if (obs[k] !== model_out(k)) begin
          tests_failed++;
          $display("FAIL random_out dut%0d cyc%0d: got %b want %b", k, i, obs[k], model_out(k));
        end
        if (obs_sc[k] !== exp_cnt(m_scnt[k])) begin
          tests_failed++;
          $display("FAIL random_scnt dut%0d cyc%0d: got %0d want %0d", k, i, obs_sc[k], exp_cnt(m_scnt[k]));
        end
        if (obs_fc[k] !== exp_cnt(m_fcnt[k])) begin
          tests_failed++;
          $display("FAIL random_fcnt dut%0d cyc%0d: got %0d want %0d", k, i, obs_fc[k], exp_cnt(m_fcnt[k]));
        end
      end
      model_advance();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_lu_redirect();
    test_flush();
    test_trap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
